// File: rtl/scaler_h_linear_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_h_linear_pkg                                                  |
// | Shared state encoding and widths for the horizontal linear scaler.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package scaler_h_linear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GEN  = 2'd2
  } scaler_state_t;

  localparam int c_x_width   = 24;
  localparam int c_num_banks = 2;

endpackage
`default_nettype wire

// File: rtl/scaler_h_linear_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_h_linear_table                                                |
// | Fractional position -> blend coefficients, one registered stage.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scaler_h_linear_table #(
  parameter int LINE_STEP = 4096,
  parameter int COE_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(LINE_STEP)-1:0] dx,
  output logic [COE_WIDTH-1:0]         coe0,
  output logic [COE_WIDTH-1:0]         coe1
);

  localparam int c_frac    = $clog2(LINE_STEP);
  localparam int c_coe_one = 2 ** (COE_WIDTH - 1);

  logic [COE_WIDTH-1:0] w_coe1;

  // Rescale dx from the LINE_STEP grid onto the coefficient grid.
  if (c_frac >= COE_WIDTH - 1) begin : g_shr
    assign w_coe1 = COE_WIDTH'(dx >> (c_frac - (COE_WIDTH - 1)));
  end else begin : g_shl
    assign w_coe1 = COE_WIDTH'(dx) << ((COE_WIDTH - 1) - c_frac);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coe0 <= '0;
      coe1 <= '0;
    end else begin
      coe0 <= COE_WIDTH'(c_coe_one) - w_coe1;
      coe1 <= w_coe1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scaler_h_linear.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scaler_h_linear                                                      |
// | Ping-pong line buffer + linear interpolation horizontal scaler.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scaler_h_linear
  import scaler_h_linear_pkg::*;
#(
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int LINE_STEP        = 4096,
  parameter int PIXEL_WIDTH      = 12,
  parameter int SPARSE_OUT       = 2,
  parameter int COE_WIDTH        = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            scale_step,
  input  logic [15:0]            line_in_size,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   ovf_o
);

  localparam int c_aw       = $clog2(LINE_IN_SIZE_MAX);
  localparam int c_frac     = $clog2(LINE_STEP);
  localparam int c_pw       = $clog2(SPARSE_OUT + 1);
  localparam int c_mw       = COE_WIDTH + PIXEL_WIDTH;
  localparam int c_sw       = c_mw + 1;
  localparam int c_round    = 2 ** (COE_WIDTH - 2);
  localparam int c_pix_max  = 2 ** PIXEL_WIDTH - 1;

  // ---------------- write side ----------------
  logic [15:0] r_wcnt;
  logic        r_wsel;
  logic        r_pending;
  logic        r_pend_bank;
  logic        r_pend_vs;
  logic        r_line_vs;
  logic [15:0] w_waddr;
  logic [15:0] w_wcount;
  logic        w_line_start;
  logic        w_cur_vs;
  logic        w_complete;

  scaler_state_t r_state;

  assign w_line_start = hs_i | vs_i;
  assign w_waddr      = w_line_start ? 16'd0 : r_wcnt;
  assign w_wcount     = w_waddr + 16'd1;
  assign w_cur_vs     = w_line_start ? vs_i : r_line_vs;
  assign w_complete   = de_i && (w_wcount == line_in_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_wsel      <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_vs   <= 1'b0;
      r_line_vs   <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      ovf_o <= 1'b0;
      if (r_state == ST_LOAD) r_pending <= 1'b0;
      if (de_i) begin
        r_wcnt    <= w_complete ? 16'd0 : w_wcount;
        r_line_vs <= w_cur_vs;
        // A fresh completion always wins over the LOAD clear so it is not lost.
        if (w_complete) begin
          r_wsel      <= ~r_wsel;
          r_pend_bank <= r_wsel;
          r_pend_vs   <= w_cur_vs;
          r_pending   <= 1'b1;
          ovf_o       <= r_pending && (r_state != ST_LOAD);
        end
      end
    end
  end

  // ---------------- line buffers ----------------
  logic [c_aw-1:0]        w_rd_addr;
  logic [PIXEL_WIDTH-1:0] w_q [c_num_banks];
  logic [PIXEL_WIDTH-1:0] w_rd_data;
  logic                   r_rsel;

  for (genvar b = 0; b < c_num_banks; b++) begin : g_bank
    (* ram_style = "block" *) logic [PIXEL_WIDTH-1:0] r_mem [LINE_IN_SIZE_MAX];
    logic [PIXEL_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (de_i && (r_wsel == 1'(b))) r_mem[w_waddr[c_aw-1:0]] <= di_i;
      r_q <= r_mem[w_rd_addr];
    end

    assign w_q[b] = r_q;
  end

  assign w_rd_data = w_q[r_rsel];

  // ---------------- read / generate FSM ----------------
  logic [c_x_width-1:0] r_x;
  logic [c_x_width-1:0] r_xmax;
  logic [c_x_width-1:0] r_step;
  logic [c_aw-1:0]      r_last;
  logic [c_pw-1:0]      r_phase;
  logic                 r_first;
  logic                 r_gen_vs;
  logic [c_x_width:0]   w_x_next;
  logic [c_aw-1:0]      w_idx0;
  logic [c_aw-1:0]      w_idx1;
  logic                 w_slot_start;

  assign w_x_next     = {1'b0, r_x} + {1'b0, r_step};
  assign w_idx0       = c_aw'(r_x >> c_frac);
  assign w_idx1       = (w_idx0 >= r_last) ? r_last : w_idx0 + 1'b1;
  assign w_rd_addr    = (r_phase == c_pw'(1)) ? w_idx1 : w_idx0;
  assign w_slot_start = (r_state == ST_GEN) && (r_phase == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_xmax   <= '0;
      r_step   <= '0;
      r_last   <= '0;
      r_rsel   <= 1'b0;
      r_phase  <= '0;
      r_first  <= 1'b0;
      r_gen_vs <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (r_pending) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_rsel   <= r_pend_bank;
          r_x      <= '0;
          r_xmax   <= c_x_width'(line_in_size - 16'd1) << c_frac;
          r_step   <= (scale_step == 16'd0) ? c_x_width'(LINE_STEP) : c_x_width'(scale_step);
          r_last   <= c_aw'(line_in_size - 16'd1);
          r_gen_vs <= r_pend_vs;
          r_first  <= 1'b1;
          r_phase  <= '0;
          r_state  <= ST_GEN;
        end
        ST_GEN: begin
          if (r_phase == c_pw'(SPARSE_OUT)) begin
            r_phase <= '0;
            r_x     <= w_x_next[c_x_width-1:0];
            r_first <= 1'b0;
            if (w_x_next > {1'b0, r_xmax}) r_state <= ST_IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- interpolation datapath ----------------
  logic [COE_WIDTH-1:0]   w_coe0;
  logic [COE_WIDTH-1:0]   w_coe1;
  logic [PIXEL_WIDTH-1:0] r_p0;
  logic [c_mw-1:0]        r_m0;
  logic [c_mw-1:0]        r_m1;
  logic [c_sw-1:0]        r_sum;
  logic [c_sw-1:0]        w_shifted;
  logic [PIXEL_WIDTH-1:0] w_sat;
  logic [3:0]             r_v;
  logic [3:0]             r_h;
  logic [3:0]             r_s;

  scaler_h_linear_table #(
    .LINE_STEP (LINE_STEP),
    .COE_WIDTH (COE_WIDTH)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .dx    (r_x[c_frac-1:0]),
    .coe0  (w_coe0),
    .coe1  (w_coe1)
  );

  assign w_shifted = r_sum >> (COE_WIDTH - 1);
  assign w_sat     = (w_shifted > c_sw'(c_pix_max)) ? '1 : w_shifted[PIXEL_WIDTH-1:0];

  // Slot cycle0 reads p0, cycle1 reads p1; product, sum and output follow on fixed stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0  <= '0;
      r_m0  <= '0;
      r_m1  <= '0;
      r_sum <= '0;
      r_v   <= '0;
      r_h   <= '0;
      r_s   <= '0;
      do_o  <= '0;
      de_o  <= 1'b0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
    end else begin
      r_p0  <= w_rd_data;
      r_m0  <= c_mw'(w_coe0) * c_mw'(r_p0);
      r_m1  <= c_mw'(w_coe1) * c_mw'(w_rd_data);
      r_sum <= c_sw'(r_m0) + c_sw'(r_m1) + c_sw'(c_round);
      r_v   <= {r_v[2:0], w_slot_start};
      r_h   <= {r_h[2:0], w_slot_start & r_first};
      r_s   <= {r_s[2:0], w_slot_start & r_first & r_gen_vs};
      de_o  <= r_v[3];
      hs_o  <= r_h[3];
      vs_o  <= r_s[3];
      if (r_v[3]) do_o <= w_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scaler_h_linear.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scaler_h_linear                                                   |
// | Randomised bench with an arithmetic reference of the scaled line.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_scaler_h_linear;

  localparam int LSTEP = 4096;
  localparam int SP    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] scale_step = 16'd4096;
  logic [15:0] line_in_size = 16'd8;
  logic [11:0] di_i = '0;
  logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [11:0] do_o;
  logic        de_o, hs_o, vs_o, ovf_o;

  scaler_h_linear dut (
    .clk (clk), .rst_n (rst_n), .scale_step (scale_step), .line_in_size (line_in_size),
    .di_i (di_i), .de_i (de_i), .hs_i (hs_i), .vs_i (vs_i),
    .do_o (do_o), .de_o (de_o), .hs_o (hs_o), .vs_o (vs_o), .ovf_o (ovf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor: collects every emitted pixel with its strobes and cycle.
  int out_px[$];
  bit out_hs[$];
  bit out_vs[$];
  int out_cyc[$];
  int consec = 0, xcnt = 0, ovf_cnt = 0;
  bit prev_de = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($isunknown({de_o, hs_o, vs_o, ovf_o})) xcnt++;
      if (de_o === 1'b1) begin
        if ($isunknown(do_o)) xcnt++;
        if (prev_de) consec++;
        out_px.push_back(int'(do_o));
        out_hs.push_back(hs_o);
        out_vs.push_back(vs_o);
        out_cyc.push_back(cyc);
      end
      if (ovf_o === 1'b1) ovf_cnt++;
      prev_de = (de_o === 1'b1);
    end else begin
      prev_de = 1'b0;
    end
  end

  int px[64];
  int exp_px[$];
  int last_px_cyc;

  // Reference: walk x over [0, (n-1)*LSTEP] and blend neighbours with rounding.
  function automatic void build_expected(int n, int step);
    longint s, xmax, i0, i1, dx, c1, v;
    exp_px.delete();
    s = (step == 0) ? LSTEP : step;
    xmax = longint'(n - 1) * LSTEP;
    for (longint x = 0; x <= xmax; x += s) begin
      i0 = x / LSTEP;
      i1 = (i0 + 1 > n - 1) ? n - 1 : i0 + 1;
      dx = x % LSTEP;
      c1 = dx * 512 / LSTEP;
      v  = ((512 - c1) * px[int'(i0)] + c1 * px[int'(i1)] + 256) / 512;
      if (v > 4095) v = 4095;
      exp_px.push_back(int'(v));
    end
  endfunction

  task automatic clear_mon();
    out_px.delete(); out_hs.delete(); out_vs.delete(); out_cyc.delete();
  endtask

  task automatic send_line(input int n, input int step, input bit vs);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        line_in_size = 16'(n);
        scale_step   = 16'(step);
      end
      de_i = 1'b1; hs_i = (i == 0); vs_i = vs && (i == 0); di_i = 12'(px[i]);
    end
    last_px_cyc = cyc;
    @(posedge clk); #1;
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = n * (SP + 1) + 64;
    while (out_px.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic run_line(input int n, input int step, input bit vs);
    clear_mon();
    build_expected(n, step);
    send_line(n, step, vs);
    wait_outputs(exp_px.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({de_o, hs_o, vs_o, ovf_o} !== 4'b0 || do_o !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got de/hs/vs/ovf=%b do=%0d, expected 0000 do=0", {de_o, hs_o, vs_o, ovf_o}, do_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_one_to_one();
    int hs_total;
    for (int i = 0; i < 8; i++) px[i] = i;
    run_line(8, 4096, 1'b1);
    n_checks++;
    if (out_px.size() !== 8) begin
      n_fail++; $display("FAIL one_to_one count: got %0d expected 8", out_px.size());
    end
    for (int i = 0; i < 8 && i < out_px.size(); i++) begin
      n_checks++;
      if (out_px[i] !== i) begin
        n_fail++; $display("FAIL one_to_one px[%0d]: got %0d expected %0d", i, out_px[i], i);
      end
    end
    hs_total = 0;
    foreach (out_hs[i]) hs_total += int'(out_hs[i]);
    n_checks++;
    if (out_px.size() == 0 || out_hs[0] !== 1'b1 || out_vs[0] !== 1'b1 || hs_total != 1) begin
      n_fail++; $display("FAIL one_to_one strobes: hs_total=%0d, expected hs/vs on first pixel only", hs_total);
    end
    for (int i = 1; i < out_cyc.size(); i++) begin
      n_checks++;
      if (out_cyc[i] - out_cyc[i-1] !== SP + 1) begin
        n_fail++; $display("FAIL one_to_one spacing[%0d]: got %0d expected %0d", i, out_cyc[i] - out_cyc[i-1], SP + 1);
      end
    end
    n_checks++;
    if (out_cyc.size() == 0 || out_cyc[0] - last_px_cyc !== 8) begin
      n_fail++; $display("FAIL one_to_one latency: got %0d expected 8", (out_cyc.size() == 0) ? -1 : out_cyc[0] - last_px_cyc);
    end
  endtask

  task automatic test_upscale_2x();
    px[0] = 0; px[1] = 100; px[2] = 200; px[3] = 300;
    run_line(4, 2048, 1'b0);
    n_checks++;
    if (out_px.size() !== 7) begin
      n_fail++; $display("FAIL upscale count: got %0d expected 7", out_px.size());
    end
    for (int i = 0; i < 7 && i < out_px.size(); i++) begin
      n_checks++;
      if (out_px[i] !== 50 * i || out_vs[i] !== 1'b0) begin
        n_fail++; $display("FAIL upscale px[%0d]: got %0d vs=%b expected %0d vs=0", i, out_px[i], out_vs[i], 50 * i);
      end
    end
  endtask

  task automatic test_downscale_2x();
    for (int i = 0; i < 8; i++) px[i] = 10 * i;
    run_line(8, 8192, 1'b0);
    n_checks++;
    if (out_px.size() !== 4) begin
      n_fail++; $display("FAIL downscale count: got %0d expected 4", out_px.size());
    end
    for (int i = 0; i < 4 && i < out_px.size(); i++) begin
      n_checks++;
      if (out_px[i] !== 20 * i) begin
        n_fail++; $display("FAIL downscale px[%0d]: got %0d expected %0d", i, out_px[i], 20 * i);
      end
    end
  endtask

  task automatic test_round_sat();
    px[0] = 4095; px[1] = 4095;
    run_line(2, 2048, 1'b0);
    n_checks++;
    if (out_px.size() !== 3 || out_px[1] !== 4095) begin
      n_fail++; $display("FAIL saturate: got n=%0d mid=%0d expected n=3 mid=4095", out_px.size(), (out_px.size() > 1) ? out_px[1] : -1);
    end
    px[0] = 0; px[1] = 1;
    run_line(2, 2048, 1'b0);
    n_checks++;
    if (out_px.size() !== 3 || out_px[1] !== 1) begin
      n_fail++; $display("FAIL round_half_up: got n=%0d mid=%0d expected n=3 mid=1", out_px.size(), (out_px.size() > 1) ? out_px[1] : -1);
    end
  endtask

  task automatic test_random();
    int n, step;
    bit vs;
    for (int l = 0; l < 8; l++) begin
      n = $urandom_range(2, 40);
      case ($urandom_range(0, 3))
        0: step = 0;
        1: step = $urandom_range(256, 4096);
        2: step = $urandom_range(4096, 16384);
        default: step = 4096;
      endcase
      vs = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) px[i] = $urandom_range(0, 4095);
      run_line(n, step, vs);
      n_checks++;
      if (out_px.size() !== exp_px.size()) begin
        n_fail++; $display("FAIL random[%0d] count: got %0d expected %0d (n=%0d step=%0d)", l, out_px.size(), exp_px.size(), n, step);
      end
      for (int i = 0; i < exp_px.size() && i < out_px.size(); i++) begin
        n_checks++;
        if (out_px[i] !== exp_px[i] || out_hs[i] !== (i == 0) || out_vs[i] !== (vs && i == 0)) begin
          n_fail++;
          $display("FAIL random[%0d] px[%0d]: got %0d hs=%b vs=%b expected %0d hs=%b vs=%b",
                   l, i, out_px[i], out_hs[i], out_vs[i], exp_px[i], i == 0, vs && i == 0);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int ovf0, hs_total, vs_total;
    ovf0 = ovf_cnt;
    clear_mon();
    for (int i = 0; i < 16; i++) px[i] = 200 * i;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        line_in_size = 16'd16; scale_step = 16'd512;
        de_i = 1'b1; hs_i = (i == 0); vs_i = (i == 0) && (l == 0); di_i = 12'(px[i]);
      end
    end
    @(posedge clk); #1;
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    wait_outputs(242);
    hs_total = 0; vs_total = 0;
    foreach (out_hs[i]) begin
      hs_total += int'(out_hs[i]);
      vs_total += int'(out_vs[i]);
    end
    n_checks++;
    if (ovf_cnt - ovf0 !== 1) begin
      n_fail++; $display("FAIL overflow pulses: got %0d expected 1", ovf_cnt - ovf0);
    end
    n_checks++;
    if (out_px.size() !== 242 || hs_total !== 2 || vs_total !== 1 || (out_vs.size() > 0 && out_vs[0] !== 1'b1)) begin
      n_fail++; $display("FAIL overflow lines: got n=%0d hs=%0d vs=%0d expected n=242 hs=2 vs=1", out_px.size(), hs_total, vs_total);
    end
    n_checks++;
    if (xcnt !== 0) begin
      n_fail++; $display("FAIL overflow unknowns: got %0d expected 0", xcnt);
    end
  endtask

  task automatic test_reset_mid_gen();
    int budget, n;
    for (int i = 0; i < 16; i++) px[i] = $urandom_range(0, 4095);
    clear_mon();
    send_line(16, 1024, 1'b1);
    budget = 200;
    while (out_px.size() < 5 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    n_checks++;
    if (out_px.size() < 5) begin
      n_fail++; $display("FAIL midgen_start: got %0d pixels expected at least 5", out_px.size());
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({de_o, hs_o, vs_o, ovf_o} !== 4'b0 || do_o !== 12'd0) begin
      n_fail++; $display("FAIL midgen_reset: got de/hs/vs/ovf=%b do=%0d expected 0000 do=0", {de_o, hs_o, vs_o, ovf_o}, do_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = $urandom_range(4, 20);
    for (int i = 0; i < n; i++) px[i] = $urandom_range(0, 4095);
    run_line(n, 3000, 1'b1);
    n_checks++;
    if (out_px.size() !== exp_px.size()) begin
      n_fail++; $display("FAIL after_reset count: got %0d expected %0d", out_px.size(), exp_px.size());
    end
    for (int i = 0; i < exp_px.size() && i < out_px.size(); i++) begin
      n_checks++;
      if (out_px[i] !== exp_px[i]) begin
        n_fail++; $display("FAIL after_reset px[%0d]: got %0d expected %0d", i, out_px[i], exp_px[i]);
      end
    end
    n_checks++;
    if (out_vs.size() == 0 || out_vs[0] !== 1'b1 || out_hs[0] !== 1'b1) begin
      n_fail++; $display("FAIL after_reset strobes: expected hs and vs on first pixel");
    end
  endtask

  task automatic test_spacing();
    n_checks++;
    if (consec !== 0) begin
      n_fail++; $display("FAIL de_back_to_back: got %0d consecutive de_o cycles expected 0", consec);
    end
  endtask

  initial begin
    test_reset();
    test_one_to_one();
    test_upscale_2x();
    test_downscale_2x();
    test_round_sat();
    test_random();
    test_overflow();
    test_reset_mid_gen();
    test_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
